multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Main sequencer for the multi-cycle RV32I core: one shared ALU/memory datapath, stepped
//  through fetch/decode/execute/writeback by a Moore FSM. Drives every mux select, enable
//  and write strobe of the datapath from the latched instruction fields and ALU flags.
//  Stalls on a memory ready handshake; traps permanently on unsupported opcodes.
// PARAMETERS
//  RESET_STATE  4'd0  FSM state entered on reset (FETCH); never changed in practice
// PORTS
//  CLK         in   1  system clock, rising edge
//  areset      in   1  asynchronous reset, active-low
//  op          in   7  IR[6:0]
//  funct3      in   3  IR[14:12]
//  funct7b5    in   1  IR[30]
//  Zero        in   1  ALU zero flag (combinational, current cycle)
//  SignFlag    in   1  ALU result sign flag (combinational, current cycle)
//  mem_ready   in   1  memory access completes this cycle
//  PCWrite     out  1  PC register load enable
//  AdrSrc      out  1  memory address: 0=PC, 1=Result
//  MemWrite    out  1  data memory write strobe
//  IRWrite     out  1  instruction/OldPC register load enable
//  RegWrite    out  1  register file write enable
//  ResultSrc   out  2  00=ALUOut, 01=Data reg, 10=ALUResult
//  ALUSrcA     out  2  00=PC, 01=OldPC, 10=A reg
//  ALUSrcB     out  2  00=B reg, 01=ImmExt, 10=const 4
//  ImmSrc      out  2  00=I, 01=S, 10=B, 11=J
//  ALUControl  out  3  000 ADD,001 SUB,010 AND,011 OR,100 XOR,101 SLT,110 SLL,111 SRL
//  illegal     out  1  sticky: FSM is in TRAP
//  state_o     out  4  current state (debug)
// BEHAVIOUR
//  - areset low: state=FETCH immediately; PCWrite/IRWrite/MemWrite/RegWrite forced 0 while
//    low; illegal=0; other outputs hold FETCH values. Reset mid-access aborts it, no write.
//  - Outputs are pure functions of state (+funct3/Zero/SignFlag/mem_ready where noted).
//  - Unlisted outputs are 0 / don't-care-as-0. ALUOp: 00 ADD, 01 SUB, 10 decode by funct.
//  FETCH(0):  AdrSrc=0,SrcA=00,SrcB=10,ADD,ResultSrc=10; IRWrite=PCWrite=mem_ready.
//             mem_ready ? DECODE : FETCH.
//  DECODE(1): SrcA=01,SrcB=01,ADD; ImmSrc=11 if op=JAL else 10. Next by op:
//             0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1101111->JAL,
//             1100011->BRANCH if funct3 in {000,001,100,101} else TRAP; other op->TRAP.
//  MEMADR(2): SrcA=10,SrcB=01,ADD,ImmSrc=00(lw)/01(sw) -> MEMREAD(lw)/MEMWRITE(sw).
//  MEMREAD(3): AdrSrc=1,ResultSrc=00; mem_ready ? MEMWB : MEMREAD.
//  MEMWB(4):  ResultSrc=01,RegWrite=1 -> FETCH.
//  MEMWRITE(5): AdrSrc=1,ResultSrc=00,MemWrite=1 held until mem_ready; then -> FETCH.
//  EXECR(6):  SrcA=10,SrcB=00,ALUOp=10 -> ALUWB.
//  ALUWB(7):  ResultSrc=00,RegWrite=1 -> FETCH.
//  EXECI(8):  SrcA=10,SrcB=01,ImmSrc=00,ALUOp=10 -> ALUWB.
//  JAL(9):    SrcA=01,SrcB=10,ADD,ResultSrc=00,PCWrite=1 (PC<=ALUOut target) -> ALUWB.
//  BRANCH(10): SrcA=10,SrcB=00,SUB,ResultSrc=00; PCWrite=taken:
//             000 Zero, 001 !Zero, 100 SignFlag, 101 !SignFlag. -> FETCH.
//  TRAP(11):  all enables 0, illegal=1; exit only via reset. States 12-15 -> TRAP.
//  ALU decode (ALUOp=10): f3 000: (funct7b5&op[5])?SUB:ADD; 001 SLL; 010 SLT; 011 SLT
//    (SLTU unsupported, signed); 100 XOR; 101 SRL (SRA unsupported); 110 OR; 111 AND.
//  - Latency: R/I/JAL 4 cycles, lw 5, sw 4, branch 3, each +1 per mem_ready=0 cycle.
// STRUCTURE
//  - Package rv_ctrl_pkg: state enum, opcode constants, ALUControl/ImmSrc/ResultSrc/
//    ALUSrcA/B encodings, ALUOp encoding.
//  - Sub-module alu_decoder (ALUOp,funct3,funct7b5,op5 -> ALUControl), combinational.
//  - Top: state register (async clear), next-state logic, Moore output table, branch cond.
// TESTING
//  - areset=0 mid-MEMWRITE (mem_ready=0) -> MemWrite drops same cycle, state_o=0, no write.
//  - add x3,x1,x2 (0x002081B3), mem_ready=1 -> states 0,1,6,7; RegWrite=1 only in 7,
//    ALUControl=000 in 6; sub (0x402081B3) -> ALUControl=001.
//  - lw 0x0040A183, mem_ready low 2 cycles in MEMREAD -> 0,1,2,3,3,3,4; RegWrite at 4 only.
//  - sw 0x0030A223, mem_ready=0 in MEMWRITE 3 cycles -> MemWrite=1 for 4 cycles, then FETCH.
//  - beq Zero=1 -> PCWrite=1 in state 10; bge SignFlag=1 -> PCWrite=0; blt SignFlag=1 -> 1.
//  - op=0x7F or branch funct3=010 -> TRAP after DECODE, illegal=1, all enables 0 for
//    100 cycles; areset pulse -> FETCH, illegal=0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path.
// Contents: FSM state codes, opcode constants, datapath mux/ALU encodings,
// ALUOp encoding and the small branch-condition helpers used by the sequencer.
package rv_ctrl_pkg;

  // FSM state codes; the numeric values are visible on the debug port.
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  // Supported opcodes (IR[6:0]).
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALUControl encodings.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // ALUOp: what the sequencer asks of the ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ImmSrc encodings.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // ResultSrc encodings.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA / ALUSrcB encodings.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Only beq/bne/blt/bge are implemented; anything else traps.
  function automatic logic branch_supported(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // Taken decision from the SUB flags computed in the BRANCH cycle.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic sign);
    logic taken;
    taken = 1'b0;
    case (f3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = sign;
      3'b101:  taken = ~sign;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction function fields to ALUControl.
// Ports:
//   alu_op_i      ALUOp from the sequencer (00 ADD, 01 SUB, 10 decode by funct)
//   funct3_i      IR[14:12]
//   funct7b5_i    IR[30]
//   op5_i         IR[5]; separates R-type (sub) from I-type (addi with imm bit 10 set)
//   alu_control_o ALU operation select
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_control_o = (funct7b5_i & op5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control_o = ALU_SLL;
          // sltu executes as signed slt; sra executes as srl.
          3'b010:  alu_control_o = ALU_SLT;
          3'b011:  alu_control_o = ALU_SLT;
          3'b100:  alu_control_o = ALU_XOR;
          3'b101:  alu_control_o = ALU_SRL;
          3'b110:  alu_control_o = ALU_OR;
          default: alu_control_o = ALU_AND;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multi-cycle RV32I core. A Moore FSM steps the shared
// datapath through fetch/decode/execute/writeback and drives every select,
// enable and write strobe. Unsupported opcodes park the FSM in TRAP until reset.
// Ports:
//   CLK, areset         clock (rising edge), asynchronous active-low reset
//   op/funct3/funct7b5  latched instruction fields
//   Zero, SignFlag      current-cycle ALU flags (used only in BRANCH)
//   mem_ready           memory access completes this cycle
//   PCWrite..ALUControl datapath controls
//   illegal             high while in TRAP
//   state_o             current state (debug)
// Handshake: a memory access is presented (FETCH, MEMREAD, MEMWRITE) and held
// unchanged, strobes included, every cycle until mem_ready is sampled high; the
// access completes on that edge and the FSM moves on.
module multicycle_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = S_FETCH
) (
  input  logic       CLK,
  input  logic       areset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       SignFlag,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic [3:0] state_o
);

  logic [3:0] state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c;

  always_ff @(posedge CLK or negedge areset) begin
    if (!areset) state_q <= RESET_STATE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = branch_supported(funct3) ? S_BRANCH : S_TRAP;
          default:           state_d = S_TRAP;
        endcase
      end
      // Only loads and stores reach MEMADR; op[5] tells them apart.
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_TRAP;  // TRAP and unused codes 12-15
    endcase
  end

  // Moore output table.
  always_comb begin
    pc_write_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_REG;
    ImmSrc      = IMM_I;
    alu_op      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        // PC+4 goes straight from the ALU into PC when the fetch completes.
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
      end
      S_DECODE: begin
        // Speculative branch/jump target OldPC+imm, parked in ALUOut.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        reg_write_c = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_c = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_REG;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write_c = 1'b1;
      S_EXECI: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_JAL: begin
        // PC takes the target from ALUOut; ALU forms OldPC+4 for the link write.
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_write_c = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_REG;
        alu_op     = ALUOP_SUB;
        pc_write_c = branch_taken(funct3, Zero, SignFlag);
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .op5_i         (op[5]),
    .alu_control_o (ALUControl)
  );

  // Gate the write enables with reset so an access aborted by reset never commits.
  assign PCWrite  = pc_write_c  & areset;
  assign MemWrite = mem_write_c & areset;
  assign IRWrite  = ir_write_c  & areset;
  assign RegWrite = reg_write_c & areset;
  assign illegal  = (state_q == S_TRAP);
  assign state_o  = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multi-cycle control FSM. Each cycle the driver pushes
// the hand-computed output vector for that cycle; a negedge monitor pops and
// compares it against the DUT.
module tb_multicycle_control_fsm;

  logic       CLK = 1'b0;
  logic       areset = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       SignFlag = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_o;

  localparam int W = 21;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [W-1:0] got;
  int           n_chk = 0;
  int           n_fail = 0;

  logic [6:0] ir_op = '0;
  logic [2:0] ir_f3 = '0;
  logic       ir_f7 = 1'b0;

  multicycle_control_fsm dut (
    .CLK(CLK), .areset(areset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .SignFlag(SignFlag), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal), .state_o(state_o)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  assign got = {state_o, illegal, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

  // Expected vector: st, illegal, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
  // ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl.
  function automatic logic [W-1:0] ev(input logic [3:0] st, input logic ill, pcw, adr, mw,
                                      irw, rw, input logic [1:0] rs, sa, sb, imm,
                                      input logic [2:0] alu);
    return {st, ill, pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu};
  endfunction

  function automatic logic [W-1:0] e_rst();
    return ev(4'd0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
  endfunction
  function automatic logic [W-1:0] e_fetch(input logic mr);
    return ev(4'd0, 0, mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
  endfunction
  function automatic logic [W-1:0] e_dec(input logic jal);
    return ev(4'd1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, jal ? 2'b11 : 2'b10, 3'b000);
  endfunction
  function automatic logic [W-1:0] e_aluwb();
    return ev(4'd7, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
  endfunction
  function automatic logic [W-1:0] e_trap();
    return ev(4'd11, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
  endfunction
  function automatic logic [W-1:0] e_branch(input logic pcw);
    return ev(4'd10, 0, pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
  endfunction

  // Driver tasks
  task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    ir_op = o; ir_f3 = f3; ir_f7 = f7;
  endtask

  task automatic step(input logic rst_v, input logic z, input logic s, input logic mr,
                      input logic [W-1:0] e, input string nm);
    @(posedge CLK);
    #1;
    areset = rst_v; Zero = z; SignFlag = s; mem_ready = mr;
    op = ir_op; funct3 = ir_f3; funct7b5 = ir_f7;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic run_branch(input logic [2:0] f3, input logic z, input logic s,
                            input logic pcw, input string nm);
    set_ir(7'b1100011, f3, 1'b0);
    step(1, 0, 0, 1, e_fetch(1), "br_fetch");
    step(1, 0, 0, 1, e_dec(0), "br_decode");
    step(1, z, s, 1, e_branch(pcw), nm);
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %06h expected %06h (state got %0d exp %0d)",
                 nm, got, e, got[20:17], e[20:17]);
      end
    end
  end

  initial begin
    // Reset held with mem_ready high: enables must stay low.
    set_ir(7'b0110011, 3'b000, 1'b0);
    step(0, 0, 0, 1, e_rst(), "reset_hold");

    // add x3,x1,x2
    step(1, 0, 0, 1, e_fetch(1), "add_fetch");
    step(1, 0, 0, 1, e_dec(0), "add_decode");
    step(1, 0, 0, 1, ev(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000), "add_execr");
    step(1, 0, 0, 1, e_aluwb(), "add_aluwb");

    // sub x3,x1,x2
    set_ir(7'b0110011, 3'b000, 1'b1);
    step(1, 0, 0, 1, e_fetch(1), "sub_fetch");
    step(1, 0, 0, 1, e_dec(0), "sub_decode");
    step(1, 0, 0, 1, ev(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001), "sub_execr");
    step(1, 0, 0, 1, e_aluwb(), "sub_aluwb");

    // srl (R-type f3=101) -> ALUControl 111
    set_ir(7'b0110011, 3'b101, 1'b0);
    step(1, 0, 0, 1, e_fetch(1), "srl_fetch");
    step(1, 0, 0, 1, e_dec(0), "srl_decode");
    step(1, 0, 0, 1, ev(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b111), "srl_execr");
    step(1, 0, 0, 1, e_aluwb(), "srl_aluwb");

    // addi with IR[30] set: I-type must stay ADD
    set_ir(7'b0010011, 3'b000, 1'b1);
    step(1, 0, 0, 1, e_fetch(1), "addi_fetch");
    step(1, 0, 0, 1, e_dec(0), "addi_decode");
    step(1, 0, 0, 1, ev(4'd8, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000), "addi_execi");
    step(1, 0, 0, 1, e_aluwb(), "addi_aluwb");

    // lw with one fetch stall, then two MEMREAD stalls
    set_ir(7'b0000011, 3'b010, 1'b0);
    step(1, 0, 0, 0, e_fetch(0), "lw_fetch_stall");
    step(1, 0, 0, 1, e_fetch(1), "lw_fetch");
    step(1, 0, 0, 1, e_dec(0), "lw_decode");
    step(1, 0, 0, 1, ev(4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000), "lw_memadr");
    step(1, 0, 0, 0, ev(4'd3, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "lw_memread0");
    step(1, 0, 0, 0, ev(4'd3, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "lw_memread1");
    step(1, 0, 0, 1, ev(4'd3, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "lw_memread2");
    step(1, 0, 0, 1, ev(4'd4, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000), "lw_memwb");

    // sw with three MEMWRITE stalls: MemWrite high four cycles
    set_ir(7'b0100011, 3'b010, 1'b0);
    step(1, 0, 0, 1, e_fetch(1), "sw_fetch");
    step(1, 0, 0, 1, e_dec(0), "sw_decode");
    step(1, 0, 0, 1, ev(4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000), "sw_memadr");
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, (i == 3), ev(4'd5, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000),
           "sw_memwrite");
    step(1, 0, 0, 1, e_fetch(1), "sw_back_fetch");

    // sw aborted by reset in MEMWRITE
    step(1, 0, 0, 1, e_dec(0), "swa_decode");
    step(1, 0, 0, 1, ev(4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000), "swa_memadr");
    step(1, 0, 0, 0, ev(4'd5, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "swa_memwrite");
    step(0, 0, 0, 0, e_rst(), "swa_reset_abort");
    step(1, 0, 0, 0, e_fetch(0), "swa_after_reset");

    // Branches
    run_branch(3'b000, 1, 0, 1, "beq_taken");
    run_branch(3'b000, 0, 0, 0, "beq_not_taken");
    run_branch(3'b001, 0, 0, 1, "bne_taken");
    run_branch(3'b101, 0, 1, 0, "bge_not_taken");
    run_branch(3'b100, 0, 1, 1, "blt_taken");

    // jal
    set_ir(7'b1101111, 3'b000, 1'b0);
    step(1, 0, 0, 1, e_fetch(1), "jal_fetch");
    step(1, 0, 0, 1, e_dec(1), "jal_decode");
    step(1, 0, 0, 1, ev(4'd9, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000), "jal_state");
    step(1, 0, 0, 1, e_aluwb(), "jal_aluwb");

    // Unsupported opcode: TRAP for 100 cycles while inputs wiggle
    set_ir(7'h7F, 3'b000, 1'b0);
    step(1, 0, 0, 1, e_fetch(1), "bad_fetch");
    step(1, 0, 0, 1, e_dec(0), "bad_decode");
    for (int i = 0; i < 100; i++)
      step(1, i[0], ~i[0], i[1], e_trap(), "trap_hold");
    step(0, 0, 0, 1, e_rst(), "trap_reset");
    step(1, 0, 0, 1, e_fetch(1), "trap_exit_fetch");

    // Unsupported branch funct3 -> TRAP
    set_ir(7'b1100011, 3'b010, 1'b0);
    step(1, 0, 0, 1, e_dec(0), "badbr_decode");
    step(1, 1, 1, 1, e_trap(), "badbr_trap0");
    step(1, 0, 0, 1, e_trap(), "badbr_trap1");
    step(0, 0, 0, 0, e_rst(), "badbr_reset");
    step(1, 0, 0, 0, e_fetch(0), "badbr_exit_fetch");

    // Drain: every pushed expectation must have been checked.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
